// File: rtl/scr1_dmem_wbuf_pkg.sv
// Memory-interface command, width and response encodings shared by the
// data-memory write buffer, the core data port and the TCM data port.
package scr1_dmem_wbuf_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_dmem_wbuf.sv
// Posted-write buffer between the core data port and the single-port TCM.
// Writes retire to the core in one cycle and drain in order when the TCM is
// free; reads bypass the buffer unless they alias a buffered word, in which
// case they wait until that word has drained so read-after-write stays ordered.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module scr1_dmem_wbuf
  import scr1_dmem_wbuf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int AWIDTH = `SCR1_DMEM_AWIDTH,
  parameter int DWIDTH = `SCR1_DMEM_DWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 core_dmem_req,
  input  type_scr1_mem_cmd_e   core_dmem_cmd,
  input  type_scr1_mem_width_e core_dmem_width,
  input  logic [AWIDTH-1:0]    core_dmem_addr,
  input  logic [DWIDTH-1:0]    core_dmem_wdata,
  output logic                 core_dmem_req_ack,
  output logic [DWIDTH-1:0]    core_dmem_rdata,
  output type_scr1_mem_resp_e  core_dmem_resp,
  output logic                 tcm_dmem_req,
  output type_scr1_mem_cmd_e   tcm_dmem_cmd,
  output type_scr1_mem_width_e tcm_dmem_width,
  output logic [AWIDTH-1:0]    tcm_dmem_addr,
  output logic [DWIDTH-1:0]    tcm_dmem_wdata,
  input  logic                 tcm_dmem_req_ack,
  input  logic [DWIDTH-1:0]    tcm_dmem_rdata,
  input  type_scr1_mem_resp_e  tcm_dmem_resp,
  output logic                 wbuf_empty,
  output logic                 wbuf_err,
  input  logic                 wbuf_err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_WAIT = 2'b01,
    ST_WR_WAIT = 2'b10
  } state_e;

  state_e               r_state;
  state_e               w_next_state;
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [PW:0]          r_count;
  logic                 r_wr_resp;
  logic                 r_err;
  logic                 r_drain_hold;

  logic [AWIDTH-1:0]    r_addr  [DEPTH];
  type_scr1_mem_width_e r_width [DEPTH];
  logic [DWIDTH-1:0]    r_wdata [DEPTH];

  logic                 w_is_rd;
  logic                 w_is_wr;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_hazard;
  logic                 w_rd_ack;
  logic                 w_drain_issue;
  logic [PW-1:0]        w_off;

  assign w_is_wr = core_dmem_req && (core_dmem_cmd == SCR1_MEM_CMD_WR);
  assign w_is_rd = core_dmem_req && (core_dmem_cmd == SCR1_MEM_CMD_RD);
  assign w_push  = w_is_wr && (r_count < FULL_CNT);
  assign w_pop   = (r_state == ST_WR_WAIT) && (tcm_dmem_resp != SCR1_MEM_RESP_NOTRDY);

  assign core_dmem_req_ack = w_push || w_rd_ack;
  assign core_dmem_rdata   = tcm_dmem_rdata;
  assign wbuf_empty        = (r_count == '0) && (r_state != ST_WR_WAIT);
  assign wbuf_err          = r_err;

  // A read aliases the buffer if any live entry, head-in-flight included, holds the same word.
  always_comb begin
    w_hazard = 1'b0;
    w_off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_rd_ptr;
      if (({1'b0, w_off} < r_count) &&
          (r_addr[i][AWIDTH-1:2] == core_dmem_addr[AWIDTH-1:2])) begin
        w_hazard = 1'b1;
      end
    end
  end

  // TCM arbitration and response routing; a raised drain request is never displaced by a read.
  always_comb begin
    w_next_state   = r_state;
    w_rd_ack       = 1'b0;
    w_drain_issue  = 1'b0;
    tcm_dmem_req   = 1'b0;
    tcm_dmem_cmd   = SCR1_MEM_CMD_WR;
    tcm_dmem_width = r_width[r_rd_ptr];
    tcm_dmem_addr  = r_addr[r_rd_ptr];
    tcm_dmem_wdata = r_wdata[r_rd_ptr];
    core_dmem_resp = r_wr_resp ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
    case (r_state)
      ST_IDLE: begin
        if (!r_drain_hold && w_is_rd && !w_hazard) begin
          tcm_dmem_req   = 1'b1;
          tcm_dmem_cmd   = core_dmem_cmd;
          tcm_dmem_width = core_dmem_width;
          tcm_dmem_addr  = core_dmem_addr;
          tcm_dmem_wdata = core_dmem_wdata;
          w_rd_ack       = tcm_dmem_req_ack;
          if (tcm_dmem_req_ack) begin
            w_next_state = ST_RD_WAIT;
          end
        end else if (r_count != '0) begin
          tcm_dmem_req  = 1'b1;
          w_drain_issue = 1'b1;
          if (tcm_dmem_req_ack) begin
            w_next_state = ST_WR_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        core_dmem_resp = tcm_dmem_resp;
        if (tcm_dmem_resp != SCR1_MEM_RESP_NOTRDY) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WR_WAIT: begin
        if (w_pop) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping, FSM state, write-response flag and sticky drain error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_wr_resp    <= 1'b0;
      r_err        <= 1'b0;
      r_drain_hold <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_wr_resp    <= w_push;
      r_drain_hold <= w_drain_issue && !tcm_dmem_req_ack;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (PW+1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (PW+1)'(1);
      end
      if (w_pop && (tcm_dmem_resp == SCR1_MEM_RESP_RDY_ER)) begin
        r_err <= 1'b1;
      end else if (wbuf_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr]  <= core_dmem_addr;
      r_width[r_wr_ptr] <= core_dmem_width;
      r_wdata[r_wr_ptr] <= core_dmem_wdata;
    end
  end

endmodule

// File: tb/tb_scr1_dmem_wbuf.sv
// Self-checking bench for the data-memory write buffer: a table of core
// accesses plus hand-written sequences for stalls, hazards, errors and reset,
// with a small TCM model and scoreboard queues for expected TCM and read data.
module tb_scr1_dmem_wbuf;
  import scr1_dmem_wbuf_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 core_dmem_req;
  type_scr1_mem_cmd_e   core_dmem_cmd;
  type_scr1_mem_width_e core_dmem_width;
  logic [31:0]          core_dmem_addr;
  logic [31:0]          core_dmem_wdata;
  logic                 core_dmem_req_ack;
  logic [31:0]          core_dmem_rdata;
  type_scr1_mem_resp_e  core_dmem_resp;
  logic                 tcm_dmem_req;
  type_scr1_mem_cmd_e   tcm_dmem_cmd;
  type_scr1_mem_width_e tcm_dmem_width;
  logic [31:0]          tcm_dmem_addr;
  logic [31:0]          tcm_dmem_wdata;
  logic                 tcm_dmem_req_ack;
  logic [31:0]          tcm_dmem_rdata;
  type_scr1_mem_resp_e  tcm_dmem_resp;
  logic                 wbuf_empty;
  logic                 wbuf_err;
  logic                 wbuf_err_clr;

  typedef struct packed {
    logic [31:0]          addr;
    type_scr1_mem_width_e width;
    logic [31:0]          wdata;
  } tcmTxn_t;

  typedef struct {
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e width;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic [31:0]          expRdata;
  } vec_t;

  int numChecks = 0;
  int numErrors = 0;

  tcmTxn_t     expTcmWr[$];
  tcmTxn_t     expTcmRd[$];
  logic [31:0] expRdata[$];

  logic [31:0]         tcmMem [logic [29:0]];
  logic                respPending = 1'b0;
  type_scr1_mem_resp_e respVal = SCR1_MEM_RESP_NOTRDY;
  logic [31:0]         respData = '0;
  logic                errInject = 1'b0;
  int                  wrSeen = 0;
  int                  lastRdWrSeen = 0;

  vec_t vecs[8];

  scr1_dmem_wbuf #(.DEPTH(4), .AWIDTH(32), .DWIDTH(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .core_dmem_req     (core_dmem_req),
    .core_dmem_cmd     (core_dmem_cmd),
    .core_dmem_width   (core_dmem_width),
    .core_dmem_addr    (core_dmem_addr),
    .core_dmem_wdata   (core_dmem_wdata),
    .core_dmem_req_ack (core_dmem_req_ack),
    .core_dmem_rdata   (core_dmem_rdata),
    .core_dmem_resp    (core_dmem_resp),
    .tcm_dmem_req      (tcm_dmem_req),
    .tcm_dmem_cmd      (tcm_dmem_cmd),
    .tcm_dmem_width    (tcm_dmem_width),
    .tcm_dmem_addr     (tcm_dmem_addr),
    .tcm_dmem_wdata    (tcm_dmem_wdata),
    .tcm_dmem_req_ack  (tcm_dmem_req_ack),
    .tcm_dmem_rdata    (tcm_dmem_rdata),
    .tcm_dmem_resp     (tcm_dmem_resp),
    .wbuf_empty        (wbuf_empty),
    .wbuf_err          (wbuf_err),
    .wbuf_err_clr      (wbuf_err_clr)
  );

  // Free-running core clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence wedges beyond its own bounds.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] tcmDefault(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // TCM model: accepts requests when ack is enabled and answers one cycle later.
  always begin : tcmModel
    @(negedge clk);
    if (respPending && rst_n) begin
      tcm_dmem_resp  = respVal;
      tcm_dmem_rdata = respData;
    end else begin
      tcm_dmem_resp  = SCR1_MEM_RESP_NOTRDY;
      tcm_dmem_rdata = '0;
    end
    respPending = 1'b0;
    #2;
    if (rst_n && tcm_dmem_req && tcm_dmem_req_ack) begin
      if (tcm_dmem_cmd == SCR1_MEM_CMD_WR) begin
        if (expTcmWr.size() == 0) begin
          numChecks++;
          numErrors++;
          $display("[TB] FAIL tcmUnexpectedWr: got addr %0h expected no write", tcm_dmem_addr);
        end else begin
          tcmTxn_t e;
          e = expTcmWr.pop_front();
          checkOutput("tcmWr", {tcm_dmem_addr, tcm_dmem_width, tcm_dmem_wdata}, e);
        end
        tcmMem[tcm_dmem_addr[31:2]] = tcm_dmem_wdata;
        respVal = errInject ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        respData = '0;
        wrSeen++;
      end else begin
        if (expTcmRd.size() == 0) begin
          numChecks++;
          numErrors++;
          $display("[TB] FAIL tcmUnexpectedRd: got addr %0h expected no read", tcm_dmem_addr);
        end else begin
          tcmTxn_t e;
          e = expTcmRd.pop_front();
          checkOutput("tcmRd", {tcm_dmem_addr, tcm_dmem_width}, {e.addr, e.width});
        end
        respVal  = SCR1_MEM_RESP_RDY_OK;
        respData = tcmMem.exists(tcm_dmem_addr[31:2]) ? tcmMem[tcm_dmem_addr[31:2]]
                                                      : tcmDefault(tcm_dmem_addr);
        lastRdWrSeen = wrSeen;
      end
      respPending = 1'b1;
    end
  end

  // One core access: drive, wait (bounded) for acceptance, then check the response.
  task automatic applyStimulus(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e width,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData, input int maxWait,
                               output int waitCycles);
    @(negedge clk);
    core_dmem_req   = 1'b1;
    core_dmem_cmd   = cmd;
    core_dmem_width = width;
    core_dmem_addr  = addr;
    core_dmem_wdata = wdata;
    if (cmd == SCR1_MEM_CMD_WR) begin
      expTcmWr.push_back('{addr: addr, width: width, wdata: wdata});
    end else begin
      expTcmRd.push_back('{addr: addr, width: width, wdata: '0});
      expRdata.push_back(expData);
    end
    waitCycles = 0;
    #1;
    while (!core_dmem_req_ack && waitCycles < maxWait) begin
      @(negedge clk);
      #1;
      waitCycles++;
    end
    if (!core_dmem_req_ack) begin
      checkOutput("reqAckTimeout", core_dmem_req_ack, 1'b1);
      @(negedge clk);
      core_dmem_req = 1'b0;
      return;
    end
    @(negedge clk);
    core_dmem_req = 1'b0;
    #1;
    if (cmd == SCR1_MEM_CMD_WR) begin
      checkOutput("wrResp", core_dmem_resp, SCR1_MEM_RESP_RDY_OK);
    end else begin
      int n = 0;
      while (core_dmem_resp == SCR1_MEM_RESP_NOTRDY && n < 10) begin
        @(negedge clk);
        #1;
        n++;
      end
      checkOutput("rdResp", core_dmem_resp, SCR1_MEM_RESP_RDY_OK);
      checkOutput("rdData", core_dmem_rdata, expRdata.pop_front());
    end
  endtask

  task automatic waitEmpty(input string name);
    int n = 0;
    @(negedge clk);
    #1;
    while (!wbuf_empty && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput(name, wbuf_empty, 1'b1);
  endtask

  initial begin
    int w;
    rst_n            = 1'b0;
    core_dmem_req    = 1'b0;
    core_dmem_cmd    = SCR1_MEM_CMD_RD;
    core_dmem_width  = SCR1_MEM_WIDTH_WORD;
    core_dmem_addr   = '0;
    core_dmem_wdata  = '0;
    tcm_dmem_req_ack = 1'b0;
    tcm_dmem_rdata   = '0;
    tcm_dmem_resp    = SCR1_MEM_RESP_NOTRDY;
    wbuf_err_clr     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rstReqAck", core_dmem_req_ack, 1'b0);
    checkOutput("rstTcmReq", tcm_dmem_req, 1'b0);
    checkOutput("rstResp", core_dmem_resp, SCR1_MEM_RESP_NOTRDY);
    checkOutput("rstEmpty", wbuf_empty, 1'b1);
    checkOutput("rstErr", wbuf_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tcm_dmem_req_ack = 1'b1;

    // Single posted write drains and empties
    applyStimulus(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h100, 32'hDEADBEEF, '0, 5, w);
    checkOutput("wrAckSameCycle", w, 0);
    checkOutput("emptyBusy", wbuf_empty, 1'b0);
    waitEmpty("emptyAfterDrain");

    // Table-driven mix of writes and reads with a free-flowing TCM
    vecs[0] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h500, 32'hCAFE0001, '0};
    vecs[1] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h504, 32'h0BADF00D, '0};
    vecs[2] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h500, '0, 32'hCAFE0001};
    vecs[3] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h508, 32'h0000BEEF, '0};
    vecs[4] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h504, '0, 32'h0BADF00D};
    vecs[5] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h600, '0, 32'h5A5A0600};
    vecs[6] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h500, 32'h11112222, '0};
    vecs[7] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h502, '0, 32'h11112222};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].cmd, vecs[i].width, vecs[i].addr, vecs[i].wdata,
                    vecs[i].expRdata, 20, w);
    end
    waitEmpty("emptyAfterTable");

    // Fill with TCM stalled; fifth write waits for the first drain to complete
    tcm_dmem_req_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h700 + 32'(4*i),
                    32'hA0000000 + 32'(i), '0, 3, w);
      checkOutput("fillAck", w, 0);
    end
    @(negedge clk);
    core_dmem_req   = 1'b1;
    core_dmem_cmd   = SCR1_MEM_CMD_WR;
    core_dmem_width = SCR1_MEM_WIDTH_WORD;
    core_dmem_addr  = 32'h710;
    core_dmem_wdata = 32'hA0000004;
    expTcmWr.push_back('{addr: 32'h710, width: SCR1_MEM_WIDTH_WORD, wdata: 32'hA0000004});
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("fullNoAck", core_dmem_req_ack, 1'b0);
      @(negedge clk);
    end
    tcm_dmem_req_ack = 1'b1;
    w = 0;
    #1;
    while (!core_dmem_req_ack && w < 10) begin
      @(negedge clk);
      #1;
      w++;
    end
    checkOutput("fullAckDelay", w, 2);
    @(negedge clk);
    core_dmem_req = 1'b0;
    #1;
    checkOutput("fullWrResp", core_dmem_resp, SCR1_MEM_RESP_RDY_OK);
    waitEmpty("emptyAfterFull");

    // Read-after-write to a buffered word stalls until the word drains
    tcm_dmem_req_ack = 1'b0;
    applyStimulus(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h200, 32'h12345678, '0, 3, w);
    fork
      applyStimulus(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h200, '0, 32'h12345678, 30, w);
      begin
        repeat (4) @(negedge clk);
        #1;
        checkOutput("rawNoAck", core_dmem_req_ack, 1'b0);
        checkOutput("rawTcmFields", {tcm_dmem_req, tcm_dmem_cmd, tcm_dmem_addr},
                    {1'b1, SCR1_MEM_CMD_WR, 32'h200});
        tcm_dmem_req_ack = 1'b1;
      end
    join
    checkOutput("rawStall", w >= 4, 1'b1);
    waitEmpty("emptyAfterRaw");

    // Non-aliasing read overtakes the second of two buffered writes
    tcm_dmem_req_ack = 1'b0;
    applyStimulus(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h104, 32'h0000AAAA, '0, 3, w);
    applyStimulus(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h108, 32'h0000BBBB, '0, 3, w);
    begin
      int wrBase;
      wrBase = wrSeen;
      tcm_dmem_req_ack = 1'b1;
      applyStimulus(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h300, '0, 32'h5A5A0300, 20, w);
      checkOutput("rdPriority", lastRdWrSeen - wrBase, 1);
    end
    waitEmpty("emptyAfterPriority");

    // Byte write keeps width and address; word read of the same word is a hazard
    tcm_dmem_req_ack = 1'b0;
    applyStimulus(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h103, 32'h000000AB, '0, 3, w);
    fork
      applyStimulus(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, '0, 32'h000000AB, 30, w);
      begin
        repeat (4) @(negedge clk);
        #1;
        checkOutput("byteNoAck", core_dmem_req_ack, 1'b0);
        checkOutput("byteTcmFields", {tcm_dmem_cmd, tcm_dmem_width, tcm_dmem_addr},
                    {SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h103});
        tcm_dmem_req_ack = 1'b1;
      end
    join
    checkOutput("byteStall", w >= 4, 1'b1);
    waitEmpty("emptyAfterByte");

    // Drain error is sticky until cleared
    errInject = 1'b1;
    applyStimulus(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h400, 32'h0F0F0F0F, '0, 3, w);
    waitEmpty("emptyAfterErr");
    checkOutput("errSet", wbuf_err, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("errSticky", wbuf_err, 1'b1);
    @(negedge clk);
    wbuf_err_clr = 1'b1;
    @(negedge clk);
    wbuf_err_clr = 1'b0;
    #1;
    checkOutput("errClr", wbuf_err, 1'b0);

    // Clear coinciding with a new error: the error wins
    tcm_dmem_req_ack = 1'b0;
    applyStimulus(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h404, 32'hF0F0F0F0, '0, 3, w);
    @(negedge clk);
    tcm_dmem_req_ack = 1'b1;
    @(negedge clk);
    wbuf_err_clr = 1'b1;
    @(negedge clk);
    wbuf_err_clr = 1'b0;
    #1;
    checkOutput("errSetWins", wbuf_err, 1'b1);
    @(negedge clk);
    wbuf_err_clr = 1'b1;
    @(negedge clk);
    wbuf_err_clr = 1'b0;
    errInject = 1'b0;
    waitEmpty("emptyBeforeReset");

    // Reset with a drain pending discards everything
    tcm_dmem_req_ack = 1'b0;
    applyStimulus(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h800, 32'h88888888, '0, 3, w);
    applyStimulus(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h804, 32'h99999999, '0, 3, w);
    checkOutput("preRstTcmReq", tcm_dmem_req, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    expTcmWr.delete();
    #1;
    checkOutput("midRstTcmReq", tcm_dmem_req, 1'b0);
    checkOutput("midRstEmpty", wbuf_empty, 1'b1);
    checkOutput("midRstResp", core_dmem_resp, SCR1_MEM_RESP_NOTRDY);
    @(negedge clk);
    rst_n = 1'b1;
    tcm_dmem_req_ack = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("postRstTcmReq", tcm_dmem_req, 1'b0);
    checkOutput("postRstEmpty", wbuf_empty, 1'b1);

    checkOutput("tcmWrQueueEmpty", expTcmWr.size(), 0);
    checkOutput("tcmRdQueueEmpty", expTcmRd.size(), 0);

    $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
    $finish;
  end

endmodule
